// File: rtl/prf_2d_read_stager.sv
// Four-slice physical register file with a two-cycle skewed read/write port.
// Optional feature macro: PRF_WRITE_FIRST_EN selects write-first collision forwarding.
`ifndef SRAM_DATA_WIDTH
`define SRAM_DATA_WIDTH 8
`endif
`ifndef SIZE_PHYSICAL_TABLE
`define SIZE_PHYSICAL_TABLE 16
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 4
`endif

module prf_2d_read_stager #(
    parameter int SLICE_W = `SRAM_DATA_WIDTH,
    parameter int DEPTH   = `SIZE_PHYSICAL_TABLE,
    parameter int ADDR_W  = `SIZE_PHYSICAL_LOG
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rdValid_i,
    input  logic [ADDR_W-1:0]    rdAddr_i,
    input  logic                 wrValid_i,
    input  logic [ADDR_W-1:0]    wrAddr_i,
    input  logic [4*SLICE_W-1:0] wrData_i,
    output logic                 rdValid_o,
    output logic [ADDR_W-1:0]    phySrc_o,
    output logic [SLICE_W-1:0]   datastage0_o,
    output logic [SLICE_W-1:0]   datastage1_o,
    output logic                 rdValidHi_o,
    output logic [SLICE_W-1:0]   datastage2_o,
    output logic [SLICE_W-1:0]   datastage3_o
);

    logic [SLICE_W-1:0] mem0_q [DEPTH];
    logic [SLICE_W-1:0] mem1_q [DEPTH];
    logic [SLICE_W-1:0] mem2_q [DEPTH];
    logic [SLICE_W-1:0] mem3_q [DEPTH];

    logic                 rd_valid_d,    rd_valid_q;
    logic [ADDR_W-1:0]    phy_src_d,     phy_src_q;
    logic [SLICE_W-1:0]   data0_d,       data0_q;
    logic [SLICE_W-1:0]   data1_d,       data1_q;
    logic                 rd_valid_hi_d, rd_valid_hi_q;
    logic [SLICE_W-1:0]   data2_d,       data2_q;
    logic [SLICE_W-1:0]   data3_d,       data3_q;

    logic                 pend_valid_d,  pend_valid_q;
    logic [ADDR_W-1:0]    pend_addr_d,   pend_addr_q;
    logic [2*SLICE_W-1:0] pend_data_d,   pend_data_q;

    always_comb begin
        rd_valid_d    = rdValid_i;
        phy_src_d     = rdAddr_i;
        data0_d       = mem0_q[rdAddr_i];
        data1_d       = mem1_q[rdAddr_i];
        rd_valid_hi_d = rd_valid_q;
        data2_d       = mem2_q[phy_src_q];
        data3_d       = mem3_q[phy_src_q];
`ifdef PRF_WRITE_FIRST_EN
        if (rdValid_i && wrValid_i && (rdAddr_i == wrAddr_i)) begin
            data0_d = wrData_i[SLICE_W-1:0];
            data1_d = wrData_i[2*SLICE_W-1:SLICE_W];
        end
        // High half forwards from the write skewed by the same one cycle.
        if (pend_valid_q && (phy_src_q == pend_addr_q)) begin
            data2_d = pend_data_q[SLICE_W-1:0];
            data3_d = pend_data_q[2*SLICE_W-1:SLICE_W];
        end
`endif
        pend_valid_d = wrValid_i;
        pend_addr_d  = wrAddr_i;
        pend_data_d  = wrData_i[4*SLICE_W-1:2*SLICE_W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_q    <= 1'b0;
            phy_src_q     <= '0;
            data0_q       <= '0;
            data1_q       <= '0;
            rd_valid_hi_q <= 1'b0;
            data2_q       <= '0;
            data3_q       <= '0;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            pend_data_q   <= '0;
        end else begin
            rd_valid_q    <= rd_valid_d;
            phy_src_q     <= phy_src_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
            rd_valid_hi_q <= rd_valid_hi_d;
            data2_q       <= data2_d;
            data3_q       <= data3_d;
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
        end
    end

    // Storage is deliberately not reset; a flushed pending half is simply lost.
    always_ff @(posedge clk) begin
        if (wrValid_i) begin
            mem0_q[wrAddr_i] <= wrData_i[SLICE_W-1:0];
            mem1_q[wrAddr_i] <= wrData_i[2*SLICE_W-1:SLICE_W];
        end
        if (pend_valid_q) begin
            mem2_q[pend_addr_q] <= pend_data_q[SLICE_W-1:0];
            mem3_q[pend_addr_q] <= pend_data_q[2*SLICE_W-1:SLICE_W];
        end
    end

    assign rdValid_o    = rd_valid_q;
    assign phySrc_o     = phy_src_q;
    assign datastage0_o = data0_q;
    assign datastage1_o = data1_q;
    assign rdValidHi_o  = rd_valid_hi_q;
    assign datastage2_o = data2_q;
    assign datastage3_o = data3_q;

endmodule

// File: tb/tb_prf_2d_read_stager.sv
// Directed testbench for prf_2d_read_stager with 8-bit slices and 16 registers.
// Expected collision data follows PRF_WRITE_FIRST_EN when it is defined.
module tb_prf_2d_read_stager;

    logic        clk;
    logic        reset;
    logic        rdValid_i;
    logic [3:0]  rdAddr_i;
    logic        wrValid_i;
    logic [3:0]  wrAddr_i;
    logic [31:0] wrData_i;
    logic        rdValid_o;
    logic [3:0]  phySrc_o;
    logic [7:0]  datastage0_o;
    logic [7:0]  datastage1_o;
    logic        rdValidHi_o;
    logic [7:0]  datastage2_o;
    logic [7:0]  datastage3_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [20:0] lo_obs;
    logic [16:0] hi_obs;
    assign lo_obs = {rdValid_o, phySrc_o, datastage0_o, datastage1_o};
    assign hi_obs = {rdValidHi_o, datastage2_o, datastage3_o};

    prf_2d_read_stager #(
        .SLICE_W(8),
        .DEPTH(16),
        .ADDR_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rdValid_i(rdValid_i),
        .rdAddr_i(rdAddr_i),
        .wrValid_i(wrValid_i),
        .wrAddr_i(wrAddr_i),
        .wrData_i(wrData_i),
        .rdValid_o(rdValid_o),
        .phySrc_o(phySrc_o),
        .datastage0_o(datastage0_o),
        .datastage1_o(datastage1_o),
        .rdValidHi_o(rdValidHi_o),
        .datastage2_o(datastage2_o),
        .datastage3_o(datastage3_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdValid_i = 1'b0;
        wrValid_i = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wrValid_i = 1'b1;
        wrAddr_i  = a;
        wrData_i  = d;
        step();
        wrValid_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        rdAddr_i = 4'd0;
        wrAddr_i = 4'd0;
        wrData_i = '0;
        #1;
        total_cnt++;
        if ({lo_obs, hi_obs} !== 38'd0)
            $display("FAIL reset_initial: got %h want 0", {lo_obs, hi_obs});
        else pass_cnt++;
        rdValid_i = 1'b1;
        rdAddr_i  = 4'd5;
        step();
        step();
        total_cnt++;
        if ({lo_obs, hi_obs} !== 38'd0)
            $display("FAIL reset_held: got %h want 0", {lo_obs, hi_obs});
        else pass_cnt++;
        idle();
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        wr(4'd5, 32'h44332211);
        step();
        rdValid_i = 1'b1;
        rdAddr_i  = 4'd5;
        step();
        rdValid_i = 1'b0;
        total_cnt++;
        if (lo_obs !== {1'b1, 4'd5, 8'h11, 8'h22})
            $display("FAIL basic_lo: got %h want %h", lo_obs, {1'b1, 4'd5, 8'h11, 8'h22});
        else pass_cnt++;
        step();
        total_cnt++;
        if (hi_obs !== {1'b1, 8'h33, 8'h44})
            $display("FAIL basic_hi: got %h want %h", hi_obs, {1'b1, 8'h33, 8'h44});
        else pass_cnt++;
    endtask

    task automatic test_collision();
        logic [31:0] exp;
`ifdef PRF_WRITE_FIRST_EN
        exp = 32'h01020304;
`else
        exp = 32'hDDCCBBAA;
`endif
        wr(4'd7, 32'hDDCCBBAA);
        step();
        wrValid_i = 1'b1;
        wrAddr_i  = 4'd7;
        wrData_i  = 32'h01020304;
        rdValid_i = 1'b1;
        rdAddr_i  = 4'd7;
        step();
        idle();
        total_cnt++;
        if (lo_obs !== {1'b1, 4'd7, exp[7:0], exp[15:8]})
            $display("FAIL collide_lo: got %h want %h", lo_obs, {1'b1, 4'd7, exp[7:0], exp[15:8]});
        else pass_cnt++;
        step();
        total_cnt++;
        if (hi_obs !== {1'b1, exp[23:16], exp[31:24]})
            $display("FAIL collide_hi: got %h want %h", hi_obs, {1'b1, exp[23:16], exp[31:24]});
        else pass_cnt++;
        rdValid_i = 1'b1;
        rdAddr_i  = 4'd7;
        step();
        rdValid_i = 1'b0;
        step();
        total_cnt++;
        if ({datastage3_o, datastage2_o, datastage1_o, datastage0_o} !== 32'h01020304)
            $display("FAIL collide_after: got %h want 01020304",
                     {datastage3_o, datastage2_o, datastage1_o, datastage0_o});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        wrValid_i = 1'b1;
        wrAddr_i  = 4'd3;
        wrData_i  = 32'hAAAAAAAA;
        step();
        wrAddr_i  = 4'd4;
        wrData_i  = 32'hBBBBBBBB;
        step();
        wrValid_i = 1'b0;
        step();
        rdValid_i = 1'b1;
        rdAddr_i  = 4'd3;
        step();
        rdAddr_i  = 4'd4;
        total_cnt++;
        if (lo_obs !== {1'b1, 4'd3, 8'hAA, 8'hAA})
            $display("FAIL b2b_lo3: got %h want %h", lo_obs, {1'b1, 4'd3, 8'hAA, 8'hAA});
        else pass_cnt++;
        step();
        rdValid_i = 1'b0;
        total_cnt++;
        if (hi_obs !== {1'b1, 8'hAA, 8'hAA})
            $display("FAIL b2b_hi3: got %h want %h", hi_obs, {1'b1, 8'hAA, 8'hAA});
        else pass_cnt++;
        total_cnt++;
        if (lo_obs !== {1'b1, 4'd4, 8'hBB, 8'hBB})
            $display("FAIL b2b_lo4: got %h want %h", lo_obs, {1'b1, 4'd4, 8'hBB, 8'hBB});
        else pass_cnt++;
        step();
        total_cnt++;
        if (hi_obs !== {1'b1, 8'hBB, 8'hBB})
            $display("FAIL b2b_hi4: got %h want %h", hi_obs, {1'b1, 8'hBB, 8'hBB});
        else pass_cnt++;
    endtask

    task automatic test_pipeline();
        logic [31:0] pv [3];
        logic [20:0] elo;
        logic [16:0] ehi;
        pv[0] = 32'h14131211;
        pv[1] = 32'h24232221;
        pv[2] = 32'hAAAAAAAA;
        wr(4'd1, pv[0]);
        wr(4'd2, pv[1]);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            rdValid_i = (i < 3);
            rdAddr_i  = 4'(i + 1);
            step();
            if (i < 3) begin
                elo = {1'b1, 4'(i + 1), pv[i][7:0], pv[i][15:8]};
                total_cnt++;
                if (lo_obs !== elo)
                    $display("FAIL pipe_lo%0d: got %h want %h", i, lo_obs, elo);
                else pass_cnt++;
            end
            if (i >= 1 && i <= 3) begin
                ehi = {1'b1, pv[i-1][23:16], pv[i-1][31:24]};
                total_cnt++;
                if (hi_obs !== ehi)
                    $display("FAIL pipe_hi%0d: got %h want %h", i, hi_obs, ehi);
                else pass_cnt++;
            end
            total_cnt++;
            if ({rdValid_o, rdValidHi_o} !== {1'(i < 3), 1'(i >= 1 && i <= 3)})
                $display("FAIL pipe_valid%0d: got %b%b want %b%b", i, rdValid_o,
                         rdValidHi_o, 1'(i < 3), 1'(i >= 1 && i <= 3));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        wr(4'd9, 32'h5A5A1234);
        step();
        wr(4'd9, 32'hFFFF0000);
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({lo_obs, hi_obs} !== 38'd0)
            $display("FAIL midrst_async: got %h want 0", {lo_obs, hi_obs});
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if ({lo_obs, hi_obs} !== 38'd0)
            $display("FAIL midrst_held: got %h want 0", {lo_obs, hi_obs});
        else pass_cnt++;
        reset = 1'b1;
        step();
        rdValid_i = 1'b1;
        rdAddr_i  = 4'd9;
        step();
        rdValid_i = 1'b0;
        total_cnt++;
        if (lo_obs !== {1'b1, 4'd9, 8'h00, 8'h00})
            $display("FAIL midrst_lo: got %h want %h", lo_obs, {1'b1, 4'd9, 8'h00, 8'h00});
        else pass_cnt++;
        step();
        total_cnt++;
        if (hi_obs !== {1'b1, 8'h5A, 8'h5A})
            $display("FAIL midrst_hi: got %h want %h", hi_obs, {1'b1, 8'h5A, 8'h5A});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_collision();
        test_back_to_back();
        test_pipeline();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
